// File: rtl/rx_packetizer.sv
// -----------------------------------------------------------------------------
// rx_packetizer
//
// Frames I&Q bytes from the upstream Rx byte FIFO into one UDP payload for the
// Ethernet Tx arbiter. Each packet is a 16-byte big-endian header followed by
// 6*SAMPLES_PER_FRAME payload bytes streamed straight from the FIFO with no
// backpressure:
//   bytes  0-3  : sequence number (per run session, wraps at 2^32)
//   bytes  4-11 : timestamp latched on grant (zero unless RX_PKT_TIMESTAMP_EN)
//   bytes 12-13 : bits per sample (24)
//   bytes 14-15 : SAMPLES_PER_FRAME
//
// Optional feature macro: RX_PKT_TIMESTAMP_EN
//   defined   - the 64-bit timestamp is captured on entry to the header and
//               sent in bytes 4-11
//   undefined - bytes 4-11 are zero, no timestamp latch, timestamp unused
//
// Ports
//   clock         single clock for all logic
//   reset         asynchronous active-low reset
//   run           PC run enable (already synchronous to clock)
//   ddc_number    DDC served by this instance, added to BASE_PORT
//   fifo_rdusedw  bytes held in the upstream FIFO
//   fifo_q        FIFO read data, valid one clock after fifo_rdreq
//   fifo_clear    upstream FIFO-clear indication
//   fifo_rdreq    FIFO read strobe
//   timestamp     free-running sample-clock count
//   tx_request    packet ready, request to the Tx arbiter
//   tx_grant      one-clock grant pulse from the arbiter
//   tx_data       packet byte
//   tx_valid      tx_data valid
//   tx_sop        first packet byte
//   tx_eop        last packet byte
//   tx_port       UDP source port, BASE_PORT + ddc_number
// -----------------------------------------------------------------------------
module rx_packetizer #(
    parameter int unsigned SAMPLES_PER_FRAME = 238,
    parameter int unsigned BASE_PORT         = 1035
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [2:0]  ddc_number,
    input  logic [12:0] fifo_rdusedw,
    input  logic [7:0]  fifo_q,
    input  logic        fifo_clear,
    output logic        fifo_rdreq,
    input  logic [63:0] timestamp,
    output logic        tx_request,
    input  logic        tx_grant,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [15:0] tx_port
);

    localparam int unsigned PayloadBytes = 6 * SAMPLES_PER_FRAME;
    localparam int unsigned PacketBytes  = 16 + PayloadBytes;
    localparam int unsigned CntW         = $clog2(PacketBytes);

    localparam logic [12:0]     FrameThresh = 13'(PayloadBytes);
    localparam logic [CntW-1:0] LastIdx     = CntW'(PacketBytes - 1);
    localparam logic [CntW-1:0] RdStopIdx   = CntW'(PacketBytes - 2);
    localparam logic [CntW-1:0] RdStartIdx  = CntW'(14);
    localparam logic [CntW-1:0] HdrLastIdx  = CntW'(15);
    localparam logic [15:0]     BpsField    = 16'd24;
    localparam logic [15:0]     SpfField    = 16'(SAMPLES_PER_FRAME);
    localparam logic [15:0]     PortBase    = 16'(BASE_PORT);

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StRequest,
        StHeader,
        StPayload,
        StGap
    } state_e;

    state_e          state_q;
    logic [31:0]     seq_num_q;
    logic [CntW-1:0] byte_q;          // index of the byte currently on tx_data
    logic [7:0]      hdr_data_q;
    logic            payload_sel_q;   // tx_data follows fifo_q during payload
    logic            tx_request_q;
    logic            tx_valid_q;
    logic            tx_sop_q;
    logic            tx_eop_q;
    logic            fifo_rdreq_q;
    logic [15:0]     tx_port_q;

    logic [15:0]     port_sel;
    logic            grant_take;
    logic [3:0]      hdr_idx_next;
    logic [7:0]      hdr_byte_d;
    logic [63:0]     ts_field;

    assign port_sel     = PortBase + {13'd0, ddc_number};
    // A grant only counts while REQUEST is not being abandoned this clock.
    assign grant_take   = (state_q == StRequest) && run && !fifo_clear && tx_grant;
    assign hdr_idx_next = byte_q[3:0] + 4'd1;

`ifdef RX_PKT_TIMESTAMP_EN
    logic [63:0] ts_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else if (grant_take) begin
            ts_q <= timestamp;
        end
    end

    assign ts_field = ts_q;
`else
    logic unused_timestamp;

    assign unused_timestamp = ^timestamp;
    assign ts_field         = '0;
`endif

    // Header byte that will be on tx_data after the next clock.
    always_comb begin
        hdr_byte_d = 8'h00;
        case (hdr_idx_next)
            4'd1:    hdr_byte_d = seq_num_q[23:16];
            4'd2:    hdr_byte_d = seq_num_q[15:8];
            4'd3:    hdr_byte_d = seq_num_q[7:0];
            4'd4:    hdr_byte_d = ts_field[63:56];
            4'd5:    hdr_byte_d = ts_field[55:48];
            4'd6:    hdr_byte_d = ts_field[47:40];
            4'd7:    hdr_byte_d = ts_field[39:32];
            4'd8:    hdr_byte_d = ts_field[31:24];
            4'd9:    hdr_byte_d = ts_field[23:16];
            4'd10:   hdr_byte_d = ts_field[15:8];
            4'd11:   hdr_byte_d = ts_field[7:0];
            4'd12:   hdr_byte_d = BpsField[15:8];
            4'd13:   hdr_byte_d = BpsField[7:0];
            4'd14:   hdr_byte_d = SpfField[15:8];
            4'd15:   hdr_byte_d = SpfField[7:0];
            default: hdr_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            seq_num_q     <= '0;
            byte_q        <= '0;
            hdr_data_q    <= '0;
            payload_sel_q <= 1'b0;
            tx_request_q  <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_sop_q      <= 1'b0;
            tx_eop_q      <= 1'b0;
            fifo_rdreq_q  <= 1'b0;
            tx_port_q     <= PortBase;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_port_q <= port_sel;
                    // Holding here with run low starts the next session at 0.
                    if (!run) begin
                        seq_num_q <= '0;
                    end
                    if (run && !fifo_clear) begin
                        state_q <= StWaitData;
                    end
                end

                StWaitData: begin
                    // Port tracks ddc_number until a request is raised, then freezes.
                    tx_port_q <= port_sel;
                    if (!run || fifo_clear) begin
                        state_q <= StIdle;
                    end else if (fifo_rdusedw >= FrameThresh) begin
                        state_q      <= StRequest;
                        tx_request_q <= 1'b1;
                    end
                end

                StRequest: begin
                    if (!run || fifo_clear) begin
                        state_q      <= StIdle;
                        tx_request_q <= 1'b0;
                    end else if (grant_take) begin
                        state_q      <= StHeader;
                        tx_request_q <= 1'b0;
                        byte_q       <= '0;
                        hdr_data_q   <= seq_num_q[31:24];
                        tx_valid_q   <= 1'b1;
                        tx_sop_q     <= 1'b1;
                    end
                end

                StHeader: begin
                    tx_sop_q <= 1'b0;
                    byte_q   <= byte_q + 1'b1;
                    // Read issued under header byte 15 so fifo_q lands on payload byte 0.
                    if (byte_q == RdStartIdx) begin
                        fifo_rdreq_q <= 1'b1;
                    end
                    if (byte_q == HdrLastIdx) begin
                        state_q       <= StPayload;
                        payload_sel_q <= 1'b1;
                        hdr_data_q    <= '0;
                    end else begin
                        hdr_data_q <= hdr_byte_d;
                    end
                end

                StPayload: begin
                    if (byte_q == LastIdx) begin
                        state_q       <= StGap;
                        payload_sel_q <= 1'b0;
                        tx_valid_q    <= 1'b0;
                        tx_eop_q      <= 1'b0;
                        seq_num_q     <= seq_num_q + 32'd1;
                    end else begin
                        byte_q <= byte_q + 1'b1;
                        // The last byte needs no new read; it was fetched one clock earlier.
                        if (byte_q == RdStopIdx) begin
                            fifo_rdreq_q <= 1'b0;
                            tx_eop_q     <= 1'b1;
                        end
                    end
                end

                StGap: begin
                    // run/fifo_clear changes seen during the packet take effect here.
                    state_q <= run ? StWaitData : StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Payload bytes pass straight from the FIFO output; header bytes are registered.
    assign tx_data    = payload_sel_q ? fifo_q : hdr_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_sop     = tx_sop_q;
    assign tx_eop     = tx_eop_q;
    assign tx_request = tx_request_q;
    assign fifo_rdreq = fifo_rdreq_q;
    assign tx_port    = tx_port_q;

endmodule

// File: doc/rx_packetizer.md
RX_PACKETIZER -- requirements
Module: rx_packetizer

Interface
REQ-001 The block SHALL have parameter SAMPLES_PER_FRAME, default 238, meaning I&Q samples per packet (6 bytes each; payload = 1428 bytes).
REQ-002 The block SHALL have parameter BASE_PORT, default 1035, meaning UDP source port for DDC0.
REQ-003 The block SHALL have port clock, input, 1, single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port run, input, 1, PC run enable; must already be synchronised to clock.
REQ-006 The block SHALL have port ddc_number, input, 3, DDC served by this instance.
REQ-007 The block SHALL have port fifo_rdusedw, input, 13, bytes held in the upstream Rx byte FIFO.
REQ-008 The block SHALL have port fifo_q, input, 8, FIFO read data, valid 1 clock after fifo_rdreq.
REQ-009 The block SHALL have port fifo_clear, input, 1, upstream FIFO-clear indication.
REQ-010 The block SHALL have port fifo_rdreq, output, 1, FIFO read strobe.
REQ-011 The block SHALL have port timestamp, input, 64, free-running sample-clock count.
REQ-012 The block SHALL have port tx_request, output, 1, packet ready, request for the Ethernet Tx arbiter.
REQ-013 The block SHALL have port tx_grant, input, 1, one-clock grant pulse from the arbiter.
REQ-014 The block SHALL have port tx_data, output, 8, packet byte.
REQ-015 The block SHALL have port tx_valid, output, 1, tx_data valid.
REQ-016 The block SHALL have port tx_sop, output, 1, first packet byte.
REQ-017 The block SHALL have port tx_eop, output, 1, last packet byte.
REQ-018 The block SHALL have port tx_port, output, 16, BASE_PORT + ddc_number, held stable while tx_request or tx_valid is high.

Function
REQ-019 The packet SHALL be 16 header bytes followed by 6*SAMPLES_PER_FRAME payload bytes, all big-endian, with no backpressure once started.
REQ-020 Header bytes 0-3 SHALL be seq_num, bytes 4-11 SHALL be the timestamp field, bytes 12-13 SHALL be 16'd24 (bits per sample), and bytes 14-15 SHALL be SAMPLES_PER_FRAME.
REQ-021 The state machine SHALL have the states IDLE, WAIT_DATA, REQUEST, HEADER, PAYLOAD and GAP.
REQ-022 In IDLE the block SHALL go to WAIT_DATA when run=1 and fifo_clear=0.
REQ-023 In WAIT_DATA the block SHALL go to REQUEST when fifo_rdusedw >= 6*SAMPLES_PER_FRAME, comparing at 13-bit width.
REQ-024 In REQUEST the block SHALL hold tx_request=1 and go to HEADER on tx_grant, deasserting tx_request in the same cycle.
REQ-025 On entering HEADER the block SHALL latch the timestamp into the header register.
REQ-026 In HEADER the block SHALL drive one byte per clock with tx_valid=1 and tx_sop=1 on byte 0 only.
REQ-027 fifo_rdreq SHALL be high for exactly 6*SAMPLES_PER_FRAME consecutive clocks, first asserted on header byte 15, so that fifo_q is presented on payload byte 0.
REQ-028 In PAYLOAD tx_data SHALL equal fifo_q, and tx_eop=1 SHALL accompany the final byte.
REQ-029 After the final byte the block SHALL enter GAP for 1 clock with tx_valid=0 and increment seq_num modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-030 From GAP the block SHALL go to WAIT_DATA if run=1, else to IDLE.
REQ-031 A run or fifo_clear change during HEADER or PAYLOAD SHALL NOT truncate the packet; it SHALL take effect in GAP.
REQ-032 fifo_clear=1 in WAIT_DATA or REQUEST SHALL force IDLE next clock and drop tx_request.
REQ-033 run=0 in WAIT_DATA or REQUEST SHALL force IDLE next clock.
REQ-034 seq_num SHALL be cleared to 0 whenever the block is in IDLE with run=0, so that each run session starts at 0.
REQ-035 tx_grant SHALL be ignored outside REQUEST.
REQ-036 fifo_rdreq SHALL never assert outside the window defined in REQ-027.

Reset
REQ-037 While reset=0 the block SHALL be in IDLE with seq_num=0, tx_request=0, tx_valid=0, tx_sop=0, tx_eop=0, fifo_rdreq=0 and tx_data=0.
REQ-038 Reset asserted mid-packet SHALL abort immediately, with no further tx_valid and no seq_num increment.
REQ-039 Release of reset SHALL take effect at the next clock edge.

Configuration
REQ-040 With RX_PKT_TIMESTAMP_EN defined, header bytes 4-11 SHALL carry the timestamp latched on entry to HEADER.
REQ-041 Without RX_PKT_TIMESTAMP_EN, header bytes 4-11 SHALL be 0x00, the 64-bit latch SHALL be removed, and the timestamp port SHALL be unused.

Verification
REQ-042 Scenario: run=1, rdusedw=1428, grant after 3 clocks, FIFO bytes 0x00..0xFF ramp -> tx_request high for 3 clocks; 1444 valid bytes; header 00 00 00 00 .. 00 18 00 EE; payload byte 0 = 0x00; sop on byte 0, eop on byte 1443.
REQ-043 Scenario: three back-to-back packets with rdusedw held at 4000 -> seq 0,1,2 in bytes 0-3; exactly 1 idle clock between eop and the next request cycle.
REQ-044 Scenario: rdusedw=1427 for 100 clocks, then 1428 -> no tx_request until the clock after rdusedw reaches 1428.
REQ-045 Scenario: run drops at payload byte 500 -> full 1444 bytes still sent, then IDLE; next run session starts with seq=0.
REQ-046 Scenario: seq preloaded to 0xFFFFFFFF -> packet header FF FF FF FF; next packet 00 00 00 00.
REQ-047 Scenario: reset at header byte 7; RX_PKT_TIMESTAMP_EN both defined and undefined with timestamp=0x0123456789ABCDEF -> immediate idle outputs, fifo_rdreq never pulsed; bytes 4-11 = 01..EF with the macro, 00 without.
